multrs: RTL and testbench

- Reservation station in front of the 8-bit multiply functional unit.
- Accepts dispatched multiply micro-ops and holds up to DEPTH entries.
- Snoops the CDB to capture operand values whose tags are still pending.
- Issues one fully-ready entry at a time to the functional unit's input interface: input_transmit, operand, depvals, wbs, flags, robid, gated by the unit's busy.

---
 rtl/multrs.sv | 184 ++++++++++++++++++
 tb/tb_multrs.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multrs.sv
// Reservation station for the 8-bit multiply unit: holds dispatched micro-ops,
// captures pending operands from the CDB and issues one ready entry at a time.
module multrs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dispatch_valid,
  input  logic [7:0]            dispatch_operand,
  input  logic [1:0][7:0]       dispatch_depvals,
  input  logic [1:0][TAG_W-1:0] dispatch_deptags,
  input  logic [1:0]            dispatch_depready,
  input  logic [7:0]            dispatch_wbs,
  input  logic [7:0]            dispatch_flags,
  input  logic [TAG_W-1:0]      dispatch_robid,
  output logic                  rs_full,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_id,
  input  logic [7:0]            cdb_val,
  input  logic                  fu_busy,
  output logic                  input_transmit,
  output logic [7:0]            operand,
  output logic [1:0][7:0]       depvals,
  output logic [7:0]            wbs,
  output logic [7:0]            flags,
  output logic [TAG_W-1:0]      robid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            rdy;
    logic [1:0][7:0]       val;
    logic [1:0][TAG_W-1:0] tag;
    logic [7:0]            op;
    logic [7:0]            wbs;
    logic [7:0]            flags;
    logic [TAG_W-1:0]      robid;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t new_ent;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             cand_found;
  logic [IDX_W-1:0] issue_idx;
  logic             issue_fire;
  logic             dispatch_accept;

  logic                  xmit_q, xmit_d;
  logic [7:0]            op_q, op_d;
  logic [1:0][7:0]       dv_q, dv_d;
  logic [7:0]            wbs_q, wbs_d;
  logic [7:0]            flags_q, flags_d;
  logic [TAG_W-1:0]      robid_q, robid_d;

  // Priority encoders: lowest free slot for dispatch, lowest ready entry for issue.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cand_found = 1'b0;
    issue_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end else begin
        free_found = free_found;
      end
      if (ent_q[i].valid && (ent_q[i].rdy == 2'b11) && !cand_found) begin
        cand_found = 1'b1;
        issue_idx  = IDX_W'(i);
      end else begin
        cand_found = cand_found;
      end
    end
  end

  assign rs_full         = ~free_found;
  assign dispatch_accept = dispatch_valid & free_found;
  // xmit_q gate guarantees a dead cycle for the unit to raise busy.
  assign issue_fire      = cand_found & ~fu_busy & ~xmit_q;

  // Incoming entry, with same-cycle CDB bypass on pending operands.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.tag   = dispatch_deptags;
    new_ent.op    = dispatch_operand;
    new_ent.wbs   = dispatch_wbs;
    new_ent.flags = dispatch_flags;
    new_ent.robid = dispatch_robid;
    for (int j = 0; j < 2; j++) begin
      if (!dispatch_depready[j] && cdb_valid && (dispatch_deptags[j] == cdb_id)) begin
        new_ent.rdy[j] = 1'b1;
        new_ent.val[j] = cdb_val;
      end else begin
        new_ent.rdy[j] = dispatch_depready[j];
        new_ent.val[j] = dispatch_depvals[j];
      end
    end
  end

  // Entry next state: wakeup, issue clear and dispatch write touch distinct entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      for (int j = 0; j < 2; j++) begin
        if (cdb_valid && ent_q[i].valid && !ent_q[i].rdy[j] && (ent_q[i].tag[j] == cdb_id)) begin
          ent_d[i].rdy[j] = 1'b1;
          ent_d[i].val[j] = cdb_val;
        end else begin
          ent_d[i].rdy[j] = ent_q[i].rdy[j];
        end
      end
      if (issue_fire && (issue_idx == IDX_W'(i))) begin
        ent_d[i].valid = 1'b0;
      end else begin
        ent_d[i].valid = ent_q[i].valid;
      end
      if (dispatch_accept && (free_idx == IDX_W'(i))) begin
        ent_d[i] = new_ent;
      end else begin
        ent_d[i] = ent_d[i];
      end
    end
  end

  // Issue output next state: data registers hold between issues.
  always_comb begin
    xmit_d  = issue_fire;
    op_d    = op_q;
    dv_d    = dv_q;
    wbs_d   = wbs_q;
    flags_d = flags_q;
    robid_d = robid_q;
    if (issue_fire) begin
      op_d    = ent_q[issue_idx].op;
      dv_d    = ent_q[issue_idx].val;
      wbs_d   = ent_q[issue_idx].wbs;
      flags_d = ent_q[issue_idx].flags;
      robid_d = ent_q[issue_idx].robid;
    end else begin
      op_d    = op_q;
    end
  end

  // State registers for entries and issue outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      xmit_q  <= 1'b0;
      op_q    <= 8'h00;
      dv_q    <= '0;
      wbs_q   <= 8'h00;
      flags_q <= 8'h00;
      robid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      xmit_q  <= xmit_d;
      op_q    <= op_d;
      dv_q    <= dv_d;
      wbs_q   <= wbs_d;
      flags_q <= flags_d;
      robid_q <= robid_d;
    end
  end

  assign input_transmit = xmit_q;
  assign operand        = op_q;
  assign depvals        = dv_q;
  assign wbs            = wbs_q;
  assign flags          = flags_q;
  assign robid          = robid_q;

endmodule

// File: tb/tb_multrs.sv
// Directed bench for multrs: vector table for single-op issue and bypass,
// plus sequences for wakeup, tag mismatch, full/ordering and async reset.
module tb_multrs;

  logic             clk = 1'b0;
  logic             rst;
  logic             dispatch_valid;
  logic [7:0]       dispatch_operand;
  logic [1:0][7:0]  dispatch_depvals;
  logic [1:0][3:0]  dispatch_deptags;
  logic [1:0]       dispatch_depready;
  logic [7:0]       dispatch_wbs;
  logic [7:0]       dispatch_flags;
  logic [3:0]       dispatch_robid;
  logic             rs_full;
  logic             cdb_valid;
  logic [3:0]       cdb_id;
  logic [7:0]       cdb_val;
  logic             fu_busy;
  logic             input_transmit;
  logic [7:0]       operand;
  logic [1:0][7:0]  depvals;
  logic [7:0]       wbs;
  logic [7:0]       flags;
  logic [3:0]       robid;

  int tests = 0;
  int fails = 0;

  multrs #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_operand(dispatch_operand),
    .dispatch_depvals(dispatch_depvals), .dispatch_deptags(dispatch_deptags),
    .dispatch_depready(dispatch_depready), .dispatch_wbs(dispatch_wbs),
    .dispatch_flags(dispatch_flags), .dispatch_robid(dispatch_robid),
    .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .fu_busy(fu_busy), .input_transmit(input_transmit), .operand(operand),
    .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rdy;
    logic [7:0] v0, v1;
    logic [3:0] t0, t1;
    logic       cv;
    logic [3:0] cid;
    logic [7:0] cval;
    logic [3:0] rob;
    logic [7:0] op, wb, fl;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
  endtask

  task automatic drive_disp(input logic [1:0] rdy, input logic [7:0] v0, input logic [7:0] v1,
                            input logic [3:0] t0, input logic [3:0] t1, input logic [3:0] rob,
                            input logic [7:0] op, input logic [7:0] wb, input logic [7:0] fl);
    dispatch_valid      = 1'b1;
    dispatch_depready   = rdy;
    dispatch_depvals[0] = v0;
    dispatch_depvals[1] = v1;
    dispatch_deptags[0] = t0;
    dispatch_deptags[1] = t1;
    dispatch_robid      = rob;
    dispatch_operand    = op;
    dispatch_wbs        = wb;
    dispatch_flags      = fl;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [7:0] v);
    cdb_valid = 1'b1;
    cdb_id    = id;
    cdb_val   = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    fu_busy = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
  endtask

  int pulses;
  int last_c;
  int busy_cnt;
  logic bprev;

  initial begin
    vecs[0] = '{2'b11, 8'd3,  8'd5,  4'd0, 4'd0, 1'b0, 4'd0, 8'd0,  4'd2,  8'h2A, 8'h11, 8'h00, 8'd3,  8'd5};
    vecs[1] = '{2'b00, 8'd0,  8'd0,  4'd5, 4'd5, 1'b1, 4'd5, 8'd6,  4'd5,  8'h01, 8'h22, 8'h81, 8'd6,  8'd6};
    vecs[2] = '{2'b01, 8'hFF, 8'h00, 4'd0, 4'd9, 1'b1, 4'd9, 8'h80, 4'd7,  8'h03, 8'h33, 8'h42, 8'hFF, 8'h80};
    vecs[3] = '{2'b10, 8'h00, 8'h10, 4'd2, 4'd2, 1'b1, 4'd2, 8'h07, 4'd0,  8'h04, 8'h44, 8'h0F, 8'h07, 8'h10};
    vecs[4] = '{2'b11, 8'hAB, 8'hCD, 4'd4, 4'd4, 1'b1, 4'd4, 8'hEE, 4'd15, 8'hFF, 8'hFF, 8'hFF, 8'hAB, 8'hCD};

    rst = 1'b1;
    idle();
    fu_busy = 1'b0;
    drive_disp(2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00);
    dispatch_valid = 1'b0;
    cdb_id  = 4'd0;
    cdb_val = 8'h00;
    @(negedge clk);
    chk("reset_xmit", input_transmit, 1'b0);
    chk("reset_full", rs_full, 1'b0);
    chk("reset_robid", robid, 4'd0);
    chk("reset_depvals", depvals, 16'h0000);
    chk("reset_wbs", wbs, 8'h00);
    rst = 1'b0;

    // Table: single dispatch (with optional same-cycle CDB) issued two cycles later.
    for (int k = 0; k < 5; k++) begin
      do_reset();
      drive_disp(vecs[k].rdy, vecs[k].v0, vecs[k].v1, vecs[k].t0, vecs[k].t1,
                 vecs[k].rob, vecs[k].op, vecs[k].wb, vecs[k].fl);
      if (vecs[k].cv) cdb(vecs[k].cid, vecs[k].cval);
      @(negedge clk);
      idle();
      chk($sformatf("v%0d_no_early", k), input_transmit, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_xmit", k), input_transmit, 1'b1);
      chk($sformatf("v%0d_dv0", k), depvals[0], vecs[k].e0);
      chk($sformatf("v%0d_dv1", k), depvals[1], vecs[k].e1);
      chk($sformatf("v%0d_robid", k), robid, vecs[k].rob);
      chk($sformatf("v%0d_op", k), operand, vecs[k].op);
      chk($sformatf("v%0d_wbs", k), wbs, vecs[k].wb);
      chk($sformatf("v%0d_flags", k), flags, vecs[k].fl);
      @(negedge clk);
      chk($sformatf("v%0d_xmit_drop", k), input_transmit, 1'b0);
      chk($sformatf("v%0d_freed", k), rs_full, 1'b0);
      chk($sformatf("v%0d_hold_robid", k), robid, vecs[k].rob);
    end

    // CDB wakeup three cycles after dispatch.
    do_reset();
    drive_disp(2'b10, 8'h00, 8'd9, 4'd7, 4'd0, 4'd3, 8'h05, 8'h12, 8'h00);
    @(negedge clk);
    idle();
    chk("wake_wait0", input_transmit, 1'b0);
    @(negedge clk);
    chk("wake_wait1", input_transmit, 1'b0);
    @(negedge clk);
    chk("wake_wait2", input_transmit, 1'b0);
    cdb(4'd7, 8'd4);
    @(negedge clk);
    idle();
    chk("wake_no_bypass", input_transmit, 1'b0);
    @(negedge clk);
    chk("wake_xmit", input_transmit, 1'b1);
    chk("wake_dv0", depvals[0], 8'd4);
    chk("wake_dv1", depvals[1], 8'd9);
    chk("wake_robid", robid, 4'd3);

    // Tag mismatch, then a matching broadcast wakes both operands at once.
    do_reset();
    drive_disp(2'b00, 8'h00, 8'h00, 4'd3, 4'd3, 4'd6, 8'h06, 8'h66, 8'h01);
    @(negedge clk);
    idle();
    cdb(4'd2, 8'h55);
    @(negedge clk);
    cdb(4'd4, 8'h66);
    @(negedge clk);
    idle();
    for (int c = 0; c < 4; c++) begin
      chk("mismatch_no_issue", input_transmit, 1'b0);
      @(negedge clk);
    end
    cdb(4'd3, 8'h0C);
    @(negedge clk);
    idle();
    chk("match_no_bypass", input_transmit, 1'b0);
    @(negedge clk);
    chk("match_xmit", input_transmit, 1'b1);
    chk("match_dv0", depvals[0], 8'h0C);
    chk("match_dv1", depvals[1], 8'h0C);

    // Full and ordering under a busy-for-9-cycles unit model.
    do_reset();
    fu_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) chk("not_full_at3", rs_full, 1'b0);
      if (k == 4) chk("full_at4", rs_full, 1'b1);
      drive_disp(2'b11, 8'(k + 1), 8'(k + 2), 4'd0, 4'd0, 4'(k), 8'h10, 8'h20, 8'h30);
      @(negedge clk);
    end
    idle();
    chk("full_after_drop", rs_full, 1'b1);
    chk("no_issue_busy", input_transmit, 1'b0);
    fu_busy  = 1'b0;
    busy_cnt = 0;
    pulses   = 0;
    last_c   = -100;
    for (int c = 0; c < 80; c++) begin
      bprev = fu_busy;
      @(negedge clk);
      if (input_transmit) begin
        chk("busy_at_issue", bprev, 1'b0);
        chk("issue_order", robid, 4'(pulses));
        chk("issue_dv0", depvals[0], 8'(pulses + 1));
        if (pulses > 0) chk("pulse_gap", (c - last_c) >= 2, 1'b1);
        pulses++;
        last_c   = c;
        busy_cnt = 9;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      fu_busy = (busy_cnt != 0);
    end
    chk("pulse_count", pulses, 4);
    chk("drained", rs_full, 1'b0);
    fu_busy = 1'b0;

    // Async reset during the issue pulse with three entries still pending.
    do_reset();
    fu_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_disp(2'b11, 8'h40, 8'h41, 4'd0, 4'd0, 4'(8 + k), 8'h07, 8'h77, 8'h00);
      @(negedge clk);
    end
    idle();
    fu_busy = 1'b0;
    @(negedge clk);
    chk("pre_rst_xmit", input_transmit, 1'b1);
    chk("pre_rst_robid", robid, 4'd8);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_xmit_now", input_transmit, 1'b0);
    chk("rst_full_now", rs_full, 1'b0);
    chk("rst_robid_now", robid, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", input_transmit, 1'b0);
    end
    chk("post_rst_empty", rs_full, 1'b0);
    drive_disp(2'b11, 8'h0E, 8'h0F, 4'd0, 4'd0, 4'd12, 8'h09, 8'h99, 8'h01);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("post_rst_xmit", input_transmit, 1'b1);
    chk("post_rst_dv0", depvals[0], 8'h0E);
    chk("post_rst_robid", robid, 4'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
